square2_reg_if: RTL and testbench

- CPU-side register writer that produces the NR21–NR24 control bytes consumed by the square-2 tone channel.
- Decodes bus writes and reads to SOUND2CNT_L (0x68), SOUND2CNT_H (0x6C) and SOUNDCNT_X (0x84).
- Holds register state, generates one-cycle trigger and length-load strobes, and returns masked readback data.
- Sits between the CPU I/O bus decoder and the square2 channel / length counter logic.

---
 rtl/sound_reg_pkg.sv | 22 ++
 rtl/square2_reg_if.sv | 158 +++++++++++++++
 tb/tb_square2_reg_if.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sound_reg_pkg.sv
// rtl/sound_reg_pkg.sv - shared address map and byte masks for the sound register blocks
package sound_reg_pkg;

    localparam logic [7:0] ADDR_SOUND2CNT_L = 8'h68;
    localparam logic [7:0] ADDR_SOUND2CNT_H = 8'h6C;
    localparam logic [7:0] ADDR_SOUNDCNT_X  = 8'h84;

    // Bits that a CPU read of each byte is allowed to see
    localparam logic [7:0] RMASK_NR21 = 8'hC0;
    localparam logic [7:0] RMASK_NR22 = 8'hFF;
    localparam logic [7:0] RMASK_NR23 = 8'h00;
    localparam logic [7:0] RMASK_NR24 = 8'h40;

    // NR24 keeps only length-enable and frequency-high; trigger is a strobe, not state
    localparam logic [7:0] WMASK_NR24 = 8'h47;

    // Halfword-aligned view of a bus address (bit 0 carries no meaning)
    function automatic logic [7:0] halfword_addr(input logic [7:0] addr);
        return addr & 8'hFE;
    endfunction

endpackage

// File: rtl/square2_reg_if.sv
// rtl/square2_reg_if.sv - CPU register interface producing NR21..NR24 for square channel 2
module square2_reg_if
    import sound_reg_pkg::*;
#(
    parameter int ACK_LATENCY = 1
) (
    input  logic        system_clock,
    input  logic        reset,
    input  logic [7:0]  bus_addr,
    input  logic [15:0] bus_wdata,
    input  logic [1:0]  bus_be,
    input  logic        bus_wr,
    input  logic        bus_rd,
    output logic        bus_ack,
    output logic [15:0] bus_rdata,
    input  logic [3:0]  ch_active,
    output logic [7:0]  NR21,
    output logic [7:0]  NR22,
    output logic [7:0]  NR23,
    output logic [7:0]  NR24,
    output logic        trigger2,
    output logic        length_load2,
    output logic        sound_on
);

    generate
        if (ACK_LATENCY != 1) begin : g_bad_latency
            $error("square2_reg_if: only ACK_LATENCY = 1 is supported");
        end
    endgenerate

    logic [7:0]  nr21_q, nr21_d;
    logic [7:0]  nr22_q, nr22_d;
    logic [7:0]  nr23_q, nr23_d;
    logic [7:0]  nr24_q, nr24_d;
    logic        sound_on_q, sound_on_d;
    logic        ack_q, ack_d;
    logic [15:0] rdata_q, rdata_d;
    logic        trigger_q, trigger_d;
    logic        length_load_q, length_load_d;

    logic [7:0]  addr_hw;
    logic        rd_only;

    assign addr_hw = halfword_addr(bus_addr);
    // A combined write+read performs the write and returns zero data
    assign rd_only = bus_rd & ~bus_wr;

    // Decode the request and compute the register, strobe and readback values for the ack cycle
    always_comb begin
        nr21_d        = nr21_q;
        nr22_d        = nr22_q;
        nr23_d        = nr23_q;
        nr24_d        = nr24_q;
        sound_on_d    = sound_on_q;
        ack_d         = bus_wr | bus_rd;
        rdata_d       = 16'h0000;
        trigger_d     = 1'b0;
        length_load_d = 1'b0;

        if (bus_wr) begin
            case (addr_hw)
                ADDR_SOUND2CNT_L: begin
                    // Channel registers are frozen while the master enable is off
                    if (sound_on_q) begin
                        if (bus_be[0]) begin
                            nr21_d        = bus_wdata[7:0];
                            length_load_d = 1'b1;
                        end
                        if (bus_be[1]) begin
                            nr22_d = bus_wdata[15:8];
                        end
                    end
                end
                ADDR_SOUND2CNT_H: begin
                    if (sound_on_q) begin
                        if (bus_be[0]) begin
                            nr23_d = bus_wdata[7:0];
                        end
                        if (bus_be[1]) begin
                            nr24_d    = bus_wdata[15:8] & WMASK_NR24;
                            trigger_d = bus_wdata[15];
                        end
                    end
                end
                ADDR_SOUNDCNT_X: begin
                    if (bus_be[0]) begin
                        sound_on_d = bus_wdata[7];
                    end
                end
                default: begin
                end
            endcase

            // Powering the APU down wipes the channel registers on the same edge
            if (sound_on_q && !sound_on_d) begin
                nr21_d = 8'h00;
                nr22_d = 8'h00;
                nr23_d = 8'h00;
                nr24_d = 8'h00;
            end
        end

        if (rd_only) begin
            case (addr_hw)
                ADDR_SOUND2CNT_L: begin
                    if (bus_be[0]) rdata_d[7:0]  = nr21_q & RMASK_NR21;
                    if (bus_be[1]) rdata_d[15:8] = nr22_q & RMASK_NR22;
                end
                ADDR_SOUND2CNT_H: begin
                    if (bus_be[0]) rdata_d[7:0]  = nr23_q & RMASK_NR23;
                    if (bus_be[1]) rdata_d[15:8] = nr24_q & RMASK_NR24;
                end
                ADDR_SOUNDCNT_X: begin
                    if (bus_be[0]) rdata_d[7:0] = {sound_on_q, 3'b000, ch_active};
                end
                default: begin
                end
            endcase
        end
    end

    // Register state, ack and strobes; reset kills an in-flight ack and strobe at once
    always_ff @(posedge system_clock or negedge reset) begin
        if (!reset) begin
            nr21_q        <= 8'h00;
            nr22_q        <= 8'h00;
            nr23_q        <= 8'h00;
            nr24_q        <= 8'h00;
            sound_on_q    <= 1'b0;
            ack_q         <= 1'b0;
            rdata_q       <= 16'h0000;
            trigger_q     <= 1'b0;
            length_load_q <= 1'b0;
        end else begin
            nr21_q        <= nr21_d;
            nr22_q        <= nr22_d;
            nr23_q        <= nr23_d;
            nr24_q        <= nr24_d;
            sound_on_q    <= sound_on_d;
            ack_q         <= ack_d;
            rdata_q       <= rdata_d;
            trigger_q     <= trigger_d;
            length_load_q <= length_load_d;
        end
    end

    assign NR21         = nr21_q;
    assign NR22         = nr22_q;
    assign NR23         = nr23_q;
    assign NR24         = nr24_q;
    assign sound_on     = sound_on_q;
    assign bus_ack      = ack_q;
    assign bus_rdata    = rdata_q;
    assign trigger2     = trigger_q;
    assign length_load2 = length_load_q;

endmodule

// File: tb/tb_square2_reg_if.sv
// tb/tb_square2_reg_if.sv - self-checking bench for square2_reg_if
module tb_square2_reg_if;

    logic        system_clock = 1'b0;
    logic        reset;
    logic [7:0]  bus_addr;
    logic [15:0] bus_wdata;
    logic [1:0]  bus_be;
    logic        bus_wr;
    logic        bus_rd;
    logic        bus_ack;
    logic [15:0] bus_rdata;
    logic [3:0]  ch_active;
    logic [7:0]  NR21, NR22, NR23, NR24;
    logic        trigger2;
    logic        length_load2;
    logic        sound_on;

    int checks = 0;
    int errors = 0;

    // Reference model: NR21..NR24 as a byte array indexed by (register offset + lane)
    logic [7:0]  m_nr [4];
    logic        m_on;
    logic [7:0]  m_rmask [4];
    logic        exp_ack, exp_trig, exp_ll;
    logic [15:0] exp_rdata;

    always #5 system_clock = ~system_clock;

    square2_reg_if #(.ACK_LATENCY(1)) dut (
        .system_clock (system_clock),
        .reset        (reset),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_be       (bus_be),
        .bus_wr       (bus_wr),
        .bus_rd       (bus_rd),
        .bus_ack      (bus_ack),
        .bus_rdata    (bus_rdata),
        .ch_active    (ch_active),
        .NR21         (NR21),
        .NR22         (NR22),
        .NR23         (NR23),
        .NR24         (NR24),
        .trigger2     (trigger2),
        .length_load2 (length_load2),
        .sound_on     (sound_on)
    );

    function automatic logic [51:0] observed();
        return {bus_ack, trigger2, length_load2, sound_on, NR21, NR22, NR23, NR24, bus_rdata};
    endfunction

    function automatic logic [51:0] expected();
        return {exp_ack, exp_trig, exp_ll, m_on, m_nr[0], m_nr[1], m_nr[2], m_nr[3], exp_rdata};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_nr[i] = 8'h00;
        m_on = 1'b0;
    endtask

    // Predict the ack-cycle outcome of one request from the register map rules
    task automatic model_step(input logic wr, input logic rd, input logic [7:0] addr,
                              input logic [15:0] d, input logic [1:0] be, input logic [3:0] ch);
        logic [7:0] a;
        int base;
        logic [7:0] val;
        a = {addr[7:1], 1'b0};
        exp_ack = wr | rd;
        exp_rdata = 16'h0000;
        exp_trig = 1'b0;
        exp_ll = 1'b0;
        base = (a == 8'h68) ? 0 : 2;
        if (wr) begin
            if (a == 8'h84 && be[0]) begin
                if (m_on && !d[7]) begin
                    for (int i = 0; i < 4; i++) m_nr[i] = 8'h00;
                end
                m_on = d[7];
            end else if ((a == 8'h68 || a == 8'h6C) && m_on) begin
                for (int lane = 0; lane < 2; lane++) begin
                    if (be[lane]) begin
                        val = d[lane*8 +: 8];
                        if (base + lane == 3) begin
                            val = val & 8'h47;
                            if (d[15]) exp_trig = 1'b1;
                        end
                        if (base + lane == 0) exp_ll = 1'b1;
                        m_nr[base + lane] = val;
                    end
                end
            end
        end else if (rd) begin
            if (a == 8'h68 || a == 8'h6C) begin
                for (int lane = 0; lane < 2; lane++) begin
                    if (be[lane]) exp_rdata[lane*8 +: 8] = m_nr[base + lane] & m_rmask[base + lane];
                end
            end else if (a == 8'h84 && be[0]) begin
                exp_rdata[7:0] = {m_on, 3'b000, ch};
            end
        end
    endtask

    // Present one request for a cycle; on return outputs of that request are visible
    task automatic drive(input logic wr, input logic rd, input logic [7:0] addr,
                         input logic [15:0] d, input logic [1:0] be, input logic [3:0] ch);
        bus_wr = wr;
        bus_rd = rd;
        bus_addr = addr;
        bus_wdata = d;
        bus_be = be;
        ch_active = ch;
        model_step(wr, rd, addr, d, be, ch);
        @(posedge system_clock);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 8'h00, 16'h0000, 2'b00, 4'h0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus_wr = 1'b0; bus_rd = 1'b0; bus_addr = 8'h00; bus_wdata = 16'h0000;
        bus_be = 2'b00; ch_active = 4'h0;
        model_reset();
        repeat (3) @(posedge system_clock);
        #1;
        checks++;
        if (observed() !== 52'h0) begin
            errors++;
            $display("FAIL reset_state: got %h want 0", observed());
        end
        reset = 1'b1;
        drive(1'b0, 1'b1, 8'h68, 16'h0000, 2'b11, 4'h0);
        checks++;
        if (bus_ack !== 1'b1 || bus_rdata !== 16'h0000 || observed() !== expected()) begin
            errors++;
            $display("FAIL reset_read68: got %h want %h", observed(), expected());
        end
        idle();
        checks++;
        if (bus_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_ack_single: ack got %b want 0", bus_ack);
        end
    endtask

    task automatic test_length_load();
        drive(1'b1, 1'b0, 8'h84, 16'h0080, 2'b01, 4'h0);
        checks++;
        if (sound_on !== 1'b1 || observed() !== expected()) begin
            errors++;
            $display("FAIL sound_on_write: got %h want %h", observed(), expected());
        end
        drive(1'b1, 1'b0, 8'h68, 16'hF3BF, 2'b11, 4'h0);
        checks++;
        if (NR21 !== 8'hBF || NR22 !== 8'hF3 || length_load2 !== 1'b1 || observed() !== expected()) begin
            errors++;
            $display("FAIL nr21_nr22_write: got %h want %h", observed(), expected());
        end
        drive(1'b0, 1'b1, 8'h68, 16'h0000, 2'b11, 4'h0);
        checks++;
        if (length_load2 !== 1'b0 || bus_rdata !== 16'hF380) begin
            errors++;
            $display("FAIL read68_masked: ll=%b rdata=%h want ll=0 rdata=f380", length_load2, bus_rdata);
        end
    endtask

    task automatic test_trigger();
        drive(1'b1, 1'b0, 8'h6C, 16'hC5A0, 2'b11, 4'h0);
        checks++;
        if (NR23 !== 8'hA0 || NR24 !== 8'h45 || trigger2 !== 1'b1 || bus_ack !== 1'b1) begin
            errors++;
            $display("FAIL nr23_nr24_trigger: got %h want NR23=a0 NR24=45 trig=1 ack=1", observed());
        end
        drive(1'b0, 1'b1, 8'h6C, 16'h0000, 2'b11, 4'h0);
        checks++;
        if (trigger2 !== 1'b0 || bus_rdata !== 16'h4000 || observed() !== expected()) begin
            errors++;
            $display("FAIL read6c_masked: got %h want %h", observed(), expected());
        end
    endtask

    task automatic test_high_lane();
        drive(1'b1, 1'b0, 8'h6C, 16'h8000, 2'b10, 4'h0);
        checks++;
        if (trigger2 !== 1'b1 || NR23 !== 8'hA0 || NR24 !== 8'h00) begin
            errors++;
            $display("FAIL high_lane_trigger: got trig=%b NR23=%h NR24=%h want 1 a0 00", trigger2, NR23, NR24);
        end
    endtask

    task automatic test_sound_off();
        drive(1'b1, 1'b0, 8'h84, 16'h0000, 2'b01, 4'h0);
        checks++;
        if ({NR21, NR22, NR23, NR24} !== 32'h0 || sound_on !== 1'b0) begin
            errors++;
            $display("FAIL power_off_clear: got %h want 0", {sound_on, NR21, NR22, NR23, NR24});
        end
        drive(1'b1, 1'b0, 8'h68, 16'hFFFF, 2'b11, 4'h0);
        checks++;
        if (bus_ack !== 1'b1 || NR21 !== 8'h00 || length_load2 !== 1'b0) begin
            errors++;
            $display("FAIL write_while_off: ack=%b NR21=%h ll=%b want 1 00 0", bus_ack, NR21, length_load2);
        end
        drive(1'b0, 1'b1, 8'h84, 16'h0000, 2'b11, 4'b0101);
        checks++;
        if (bus_rdata !== 16'h0005) begin
            errors++;
            $display("FAIL read84_status: got %h want 0005", bus_rdata);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b0, 8'h84, 16'h0080, 2'b01, 4'h0);
        drive(1'b1, 1'b0, 8'h68, 16'h12C7, 2'b11, 4'h0);
        checks++;
        if (bus_ack !== 1'b1 || NR21 !== 8'hC7 || NR22 !== 8'h12 || length_load2 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_write68: got %h", observed());
        end
        drive(1'b0, 1'b1, 8'h68, 16'h0000, 2'b11, 4'h0);
        checks++;
        if (bus_ack !== 1'b1 || bus_rdata !== 16'h12C0 || length_load2 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_read68: ack=%b rdata=%h want 1 12c0", bus_ack, bus_rdata);
        end
        drive(1'b1, 1'b1, 8'h6C, 16'h8123, 2'b11, 4'h0);
        checks++;
        if (bus_ack !== 1'b1 || bus_rdata !== 16'h0000 || trigger2 !== 1'b1 ||
            NR23 !== 8'h23 || NR24 !== 8'h01) begin
            errors++;
            $display("FAIL b2b_wr_rd6c: got %h", observed());
        end
        // Next request in flight, then reset lands mid-cycle while the previous ack is high
        bus_wr = 1'b1; bus_rd = 1'b0; bus_addr = 8'h68; bus_wdata = 16'h0101; bus_be = 2'b01;
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (bus_ack !== 1'b0 || trigger2 !== 1'b0 || length_load2 !== 1'b0 || NR24 !== 8'h00) begin
            errors++;
            $display("FAIL reset_midrequest: ack=%b trig=%b ll=%b NR24=%h want 0 0 0 00",
                     bus_ack, trigger2, length_load2, NR24);
        end
        @(posedge system_clock);
        #1;
        model_reset();
        bus_wr = 1'b0; bus_rd = 1'b0;
        reset = 1'b1;
        idle();
    endtask

    task automatic test_random();
        logic [7:0] addr_tab [7];
        int op;
        logic [7:0] a;
        logic [15:0] d;
        addr_tab[0] = 8'h68; addr_tab[1] = 8'h69; addr_tab[2] = 8'h6C; addr_tab[3] = 8'h6D;
        addr_tab[4] = 8'h84; addr_tab[5] = 8'h85; addr_tab[6] = 8'h70;
        for (int it = 0; it < 400; it++) begin
            op = $urandom_range(0, 9);
            a = addr_tab[$urandom_range(0, 6)];
            if ($urandom_range(0, 15) == 0) a = 8'($urandom);
            d = 16'($urandom);
            if ({a[7:1], 1'b0} == 8'h84) d[7] = ($urandom_range(0, 4) != 0);
            case (op)
                0, 1:       drive(1'b0, 1'b0, a, d, 2'($urandom), 4'($urandom));
                2, 3, 4, 5: drive(1'b1, 1'b0, a, d, 2'($urandom), 4'($urandom));
                6, 7, 8:    drive(1'b0, 1'b1, a, d, 2'($urandom), 4'($urandom));
                default:    drive(1'b1, 1'b1, a, d, 2'($urandom), 4'($urandom));
            endcase
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL random_%0d: got %h want %h", it, observed(), expected());
            end
        end
    endtask

    initial begin
        m_rmask[0] = 8'hC0; m_rmask[1] = 8'hFF; m_rmask[2] = 8'h00; m_rmask[3] = 8'h40;
        test_reset();
        test_length_load();
        test_trigger();
        test_high_lane();
        test_sound_off();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
